// File: rtl/nios2_debug_scan_master_pkg.sv
// -----------------------------------------------------------------------------
// debug_scan_pkg
// Shared definitions for the Nios II debug scan master:
//   - scan_state_t   : scan sequencer state encoding
//   - DEBUG_IR_WIDTH : default virtual IR width
//   - DEBUG_DR_WIDTH : default scan chain length
//   - IR_*           : IR codes understood by the Nios II debug slave
// -----------------------------------------------------------------------------
package debug_scan_pkg;

    localparam int DEBUG_IR_WIDTH = 2;
    localparam int DEBUG_DR_WIDTH = 38;

    localparam logic [1:0] IR_OCIMEM_A = 2'd0;
    localparam logic [1:0] IR_OCIMEM_B = 2'd1;
    localparam logic [1:0] IR_BREAK    = 2'd2;
    localparam logic [1:0] IR_TRACE    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RESP = 3'd6
    } scan_state_t;

endpackage

// File: rtl/nios2_debug_scan_master_tck_gen.sv
// -----------------------------------------------------------------------------
// debug_scan_tck_gen
// TCK divider: TCK_DIV clk cycles low, then TCK_DIV clk cycles high.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   start      : begin generating TCK, starting with a low half-period
//   stop       : halt the generator and force TCK low
//   tck        : generated TCK (registered)
//   rise       : high in the clk cycle whose edge drives tck high
//   fall       : high in the clk cycle whose edge drives tck low
// -----------------------------------------------------------------------------
module debug_scan_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

    logic          r_run;
    logic [CW-1:0] r_cnt;
    logic          r_tck;
    logic          w_wrap;

    // Half-period ends when the counter reaches its last value.
    assign w_wrap = r_run && (r_cnt == LAST);
    assign rise   = w_wrap && !r_tck;
    assign fall   = w_wrap && r_tck;
    assign tck    = r_tck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (stop) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (r_run) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
                r_tck <= ~r_tck;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios2_debug_scan_master.sv
// -----------------------------------------------------------------------------
// nios2_debug_scan_master
// System-clock-side virtual-JTAG scan initiator for the Nios II debug slave.
// Takes one command (IR + DR), runs UIR/CDR/SDR/UDR/RTI with a generated TCK
// and returns the DR_WIDTH bits shifted out of the slave.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid-side payload must be held until that edge. cmd_ready is
// high only in IDLE; rsp_valid is high only in RESP and rsp_dr is frozen there.
//
// Ports:
//   clk, reset                     system clock, async active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_ir, cmd_skip_ir, cmd_dr    command payload (DR shifted LSB first)
//   rsp_valid/rsp_ready, rsp_dr    response handshake, captured TDO bits
//   loopback_en                    only with DEBUG_SCAN_LOOPBACK_EN defined:
//                                  capture TDI instead of TDO
//   vji_tck, vji_tdi, vji_tdo      serial scan pins
//   vji_ir_in                      current virtual IR
//   vji_uir..vji_rti               virtual state indicators
//   busy                           high from accept until response handshake
// Optional feature macro: DEBUG_SCAN_LOOPBACK_EN
// -----------------------------------------------------------------------------
module nios2_debug_scan_master
    import debug_scan_pkg::*;
#(
    parameter int IR_WIDTH = DEBUG_IR_WIDTH,
    parameter int DR_WIDTH = DEBUG_DR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic                cmd_skip_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
`ifdef DEBUG_SCAN_LOOPBACK_EN
    input  logic                loopback_en,
`endif
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic                busy
);

    localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

    scan_state_t         r_state;
    logic [DR_WIDTH-1:0] r_sh;
    logic [DR_WIDTH-1:0] r_cap;
    logic [BW-1:0]       r_bit_cnt;
    logic [IR_WIDTH-1:0] r_ir;
    logic                r_tdi;
    logic                r_uir, r_cdr, r_sdr, r_udr, r_rti;
    logic                r_rsp_valid;
    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_tck_start;

    logic w_tck, w_rise, w_fall, w_stop, w_tdo_s;

`ifdef DEBUG_SCAN_LOOPBACK_EN
    assign w_tdo_s = loopback_en ? r_tdi : vji_tdo;
`else
    assign w_tdo_s = vji_tdo;
`endif

    // The generator halts on the final RTI fall, so TCK stays low in RESP.
    assign w_stop = (r_state == ST_RTI) && w_fall;

    debug_scan_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk   (clk),
        .reset (reset),
        .start (r_tck_start),
        .stop  (w_stop),
        .tck   (w_tck),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sh        <= '0;
            r_cap       <= '0;
            r_bit_cnt   <= '0;
            r_ir        <= '0;
            r_tdi       <= 1'b0;
            r_uir       <= 1'b0;
            r_cdr       <= 1'b0;
            r_sdr       <= 1'b0;
            r_udr       <= 1'b0;
            r_rti       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_tck_start <= 1'b0;
        end else begin
            r_tck_start <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // cmd_ready is high whenever the FSM sits in IDLE.
                    if (cmd_valid) begin
                        r_sh        <= cmd_dr;
                        r_cap       <= '0;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_tck_start <= 1'b1;
                        if (cmd_skip_ir) begin
                            r_cdr   <= 1'b1;
                            r_state <= ST_CDR;
                        end else begin
                            r_uir   <= 1'b1;
                            r_ir    <= cmd_ir;
                            r_state <= ST_UIR;
                        end
                    end
                end
                ST_UIR: begin
                    if (w_fall) begin
                        r_uir   <= 1'b0;
                        r_cdr   <= 1'b1;
                        r_state <= ST_CDR;
                    end
                end
                ST_CDR: begin
                    if (w_fall) begin
                        r_cdr     <= 1'b0;
                        r_sdr     <= 1'b1;
                        r_tdi     <= r_sh[0];
                        r_bit_cnt <= '0;
                        r_state   <= ST_SDR;
                    end
                end
                ST_SDR: begin
                    // Capture on the rise cycle (slave shifts on that TCK
                    // edge); present the next TDI bit on the fall cycle.
                    if (w_rise) begin
                        r_cap <= {w_tdo_s, r_cap[DR_WIDTH-1:1]};
                        r_sh  <= r_sh >> 1;
                    end
                    if (w_fall) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_sdr   <= 1'b0;
                            r_udr   <= 1'b1;
                            r_tdi   <= 1'b0;
                            r_state <= ST_UDR;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tdi     <= r_sh[0];
                        end
                    end
                end
                ST_UDR: begin
                    if (w_fall) begin
                        r_udr   <= 1'b0;
                        r_rti   <= 1'b1;
                        r_state <= ST_RTI;
                    end
                end
                ST_RTI: begin
                    if (w_fall) begin
                        r_rti       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dr    = r_cap;
    assign busy      = r_busy;
    assign vji_tck   = w_tck;
    assign vji_tdi   = r_tdi;
    assign vji_ir_in = r_ir;
    assign vji_uir   = r_uir;
    assign vji_cdr   = r_cdr;
    assign vji_sdr   = r_sdr;
    assign vji_udr   = r_udr;
    assign vji_rti   = r_rti;

endmodule

// File: doc/nios2_debug_scan_master.md
# nios2_debug_scan_master

Virtual-JTAG scan initiator that drives the Nios II CPU debug slave from the system-clock side, replacing the `sld_virtual_jtag_basic` hub for on-chip debug agents and simulation. It accepts one scan command at a time: a 2-bit IR and a 38-bit DR. It then sequences UIR, CDR, SDR, UDR and RTI with a generated TCK, and returns the 38 bits shifted out of the slave. It sits between a host-side command source, such as a UART/Avalon debug bridge, and the debug slave's `vji_*` pins.

## Interface
Parameters:
- `IR_WIDTH`, 2, virtual IR width.
- `DR_WIDTH`, 38, scan chain length.
- `TCK_DIV`, 2, clk cycles per TCK half-period; must be ≥1.

Ports:
- `clk`  in  1  system clock; every flop is on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_ir`  in  IR_WIDTH  IR value to load.
- `cmd_skip_ir`  in  1  omit the UIR phase and keep the current `vji_ir_in`.
- `cmd_dr`  in  DR_WIDTH  data to shift in, LSB first.
- `rsp_valid`  out  1  scan result available.
- `rsp_ready`  in  1  result consumed.
- `rsp_dr`  out  DR_WIDTH  captured TDO bits; bit 0 is the first bit out.
- `vji_tck`  out  1  generated TCK.
- `vji_tdi`  out  1  serial data to the slave.
- `vji_tdo`  in  1  serial data from the slave.
- `vji_ir_in`  out  IR_WIDTH  current IR.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`  out  1 each  virtual state indicators.
- `busy`  out  1  high from command accept until the response handshake.

## Operation
- FSM states: IDLE → UIR → CDR → SDR → UDR → RTI → RESP → IDLE. When `cmd_skip_ir` is set, the FSM goes IDLE → CDR directly.
- Command accept:
  - Acceptance is `cmd_valid && cmd_ready`.
  - On accept, latch `cmd_ir`, `cmd_dr` and `cmd_skip_ir`, clear the capture register, and start the TCK generator with `vji_tck` low.
- TCK period: each TCK period is `TCK_DIV` clk cycles low, then `TCK_DIV` clk cycles high.
  - "Rise cycle" is the clk cycle that sets `vji_tck` high.
  - "Fall cycle" is the clk cycle that sets `vji_tck` low.
- Per-state TCK rises:
  - UIR, CDR, UDR and RTI each last exactly one TCK period.
  - SDR lasts exactly `DR_WIDTH` TCK periods.
- State changes, state indicators and `vji_tdi` update only at period boundaries, i.e. in the fall cycle. They are therefore stable across every TCK rise.
- UIR: `vji_ir_in` loads `cmd_ir` at UIR entry. It holds that value after the scan and until the next UIR; it does not return to 0.
- SDR shifting:
  - `vji_tdi` = shift register bit 0.
  - In each rise cycle, sample `vji_tdo` into the capture register MSB and shift right.
  - After `DR_WIDTH` rises, `rsp_dr` equals the slave's prior chain contents, LSB first.
- Exactly one indicator is high in each scan state; all indicators are low in IDLE and RESP.
- Response:
  - In RESP, `rsp_valid` = 1 and `vji_tck` = 0.
  - `rsp_dr` is held stable until `rsp_valid && rsp_ready`; the FSM then returns to IDLE.
- Command during a scan: `cmd_valid` is ignored, not queued, while `busy` is high.
- Reset values: `vji_tck`, `vji_tdi`, `vji_ir_in`, all indicators, `rsp_valid`, `rsp_dr` and `busy` = 0; `cmd_ready` = 1.
- Reset mid-scan:
  - Asserting `reset` forces all reset values asynchronously and aborts the scan.
  - No response is produced, and no partial UDR pulse is emitted.

## Timing
- Let N = `DR_WIDTH` + 4, or `DR_WIDTH` + 3 with `cmd_skip_ir`.
- `rsp_valid` rises exactly N·2·`TCK_DIV` + 1 clk cycles after the accepting edge. With defaults this is 169 cycles, or 165 with `cmd_skip_ir`.
- `cmd_ready` rises one cycle after the response handshake; back-to-back scan throughput is one scan per (latency + 2) cycles.
- `rsp_ready` may be held high in advance; RESP then lasts exactly one cycle.
- `vji_tdo` is sampled in the rise cycle, before the slave's posedge shift. The slave must therefore present TDO combinationally from its register.

## Configuration
- `DEBUG_SCAN_LOOPBACK_EN` defined:
  - Adds input `loopback_en` (1 bit).
  - While `loopback_en` is high, the sampled TDO is replaced by the current `vji_tdi`, so `rsp_dr` == `cmd_dr`.
  - The `vji_*` outputs still toggle.
- `DEBUG_SCAN_LOOPBACK_EN` undefined: the port is absent and `vji_tdo` is always used.

## Structure
- Package `debug_scan_pkg` contains:
  - the FSM state enum;
  - `DEBUG_IR_WIDTH` and `DEBUG_DR_WIDTH` defaults;
  - named IR codes for the debug slave: `IR_OCIMEM_A` = 0, `IR_OCIMEM_B` = 1, `IR_BREAK` = 2, `IR_TRACE` = 3.
- Sub-module `debug_scan_tck_gen`:
  - TCK divider with `start`/`stop` inputs;
  - outputs `tck`, `rise` and `fall` strobes.
- The FSM and shift registers stay in the top module.

## Test plan
- Reset: hold `reset` 5 cycles → all outputs at their reset values, `cmd_ready` = 1. After release, no TCK edges occur without a command.
- Basic scan:
  - Stimulus: `cmd_ir` = 2'b01, `cmd_dr` = 38'h2A_5555_AAAA; slave model preloaded with 38'h15_0F0F_F0F0.
  - Required: one UIR pulse with `vji_ir_in` = 01; exactly 38 rises with `vji_sdr` high; the model receives 38'h2A_5555_AAAA; `rsp_dr` = 38'h15_0F0F_F0F0; `rsp_valid` at cycle 169.
- Skip IR: second command with `cmd_skip_ir` = 1 → no UIR, `vji_ir_in` stays 01, `rsp_valid` at cycle 165.
- Backpressure: `rsp_ready` low for 20 cycles, with `cmd_valid` high throughout → `rsp_dr` stable, `cmd_ready` = 0, no new accept. The next command is accepted one cycle after the handshake.
- Reset mid-SDR: assert `reset` at the 10th SDR rise → `vji_tck`/`vji_sdr` = 0 immediately, no UDR, no `rsp_valid`. The next scan is correct.
- Loopback (macro defined): `loopback_en` = 1, `cmd_dr` = 38'h3F_FFFF_0001 → `rsp_dr` = 38'h3F_FFFF_0001.
